// File: rtl/regfile_rename_pkg.sv
// Shared widths, types and the "no pending producer" tag for the renamed register file.
package regfile_rename_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NUM_REGS = 2 ** REG_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [TAG_W-1:0]  tag_t;

  // MSB set means the register already holds its final value
  localparam tag_t TAG_FREE = 4'b1000;

endpackage

// File: rtl/regfile_rename_if.sv
// Commit, rename, flush and operand-read signals between the ROB/decoder side and the register file.
interface regfile_rename_if;
  import regfile_rename_pkg::*;

  logic     commit_en;
  reg_idx_t commit_reg;
  data_t    commit_data;
  tag_t     commit_tag;
  logic     rename_en;
  reg_idx_t rename_reg;
  tag_t     rename_tag;
  logic     flush;
  reg_idx_t rs1_addr;
  tag_t     rs1_tag;
  data_t    rs1_data;
  reg_idx_t rs2_addr;
  tag_t     rs2_tag;
  data_t    rs2_data;
  logic [31:0] retired_cnt;

  modport master (
    output commit_en, commit_reg, commit_data, commit_tag,
    output rename_en, rename_reg, rename_tag, flush, rs1_addr, rs2_addr,
    input  rs1_tag, rs1_data, rs2_tag, rs2_data, retired_cnt
  );

  modport slave (
    input  commit_en, commit_reg, commit_data, commit_tag,
    input  rename_en, rename_reg, rename_tag, flush, rs1_addr, rs2_addr,
    output rs1_tag, rs1_data, rs2_tag, rs2_data, retired_cnt
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational operand read port: index mux, register-0 zeroing and, when
// REGFILE_BYPASS_EN is defined, same-cycle commit-to-read forwarding.
module regfile_read_port
  import regfile_rename_pkg::*;
(
  input  reg_idx_t addr_i,
  input  data_t    data_arr_i [NUM_REGS],
  input  tag_t     tag_arr_i  [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
  input  logic     commit_en_i,
  input  reg_idx_t commit_reg_i,
  input  data_t    commit_data_i,
  input  tag_t     commit_tag_i,
`endif
  output tag_t     tag_o,
  output data_t    data_o
);

  always_comb begin
    tag_o  = tag_arr_i[addr_i];
    data_o = data_arr_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // Only forward when this commit is the newest producer, i.e. it would clear the tag
    if (commit_en_i && (addr_i == commit_reg_i) && (tag_arr_i[addr_i] == commit_tag_i)) begin
      tag_o  = TAG_FREE;
      data_o = commit_data_i;
    end
`endif
    if (addr_i == '0) begin
      tag_o  = TAG_FREE;
      data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags, ROB commit port and
// retired-instruction counter. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_rename
  import regfile_rename_pkg::*;
(
  input logic             clk,
  input logic             rst,
  regfile_rename_if.slave bus_io
);

  data_t       data_q [NUM_REGS];
  data_t       data_d [NUM_REGS];
  tag_t        tag_q  [NUM_REGS];
  tag_t        tag_d  [NUM_REGS];
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    if (bus_io.commit_en) begin
      cnt_d = cnt_q + 32'd1;
      if (bus_io.commit_reg != '0) begin
        data_d[bus_io.commit_reg] = bus_io.commit_data;
        // A newer rename keeps the register pending on its own producer
        if (tag_q[bus_io.commit_reg] == bus_io.commit_tag) begin
          tag_d[bus_io.commit_reg] = TAG_FREE;
        end
      end
    end
    if (bus_io.flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_d[i] = TAG_FREE;
      end
    end else if (bus_io.rename_en && (bus_io.rename_reg != '0)) begin
      tag_d[bus_io.rename_reg] = bus_io.rename_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '{default: '0};
      tag_q  <= '{default: TAG_FREE};
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus_io.retired_cnt = cnt_q;

  regfile_read_port u_rd1 (
    .addr_i        (bus_io.rs1_addr),
    .data_arr_i    (data_q),
    .tag_arr_i     (tag_q),
`ifdef REGFILE_BYPASS_EN
    .commit_en_i   (bus_io.commit_en),
    .commit_reg_i  (bus_io.commit_reg),
    .commit_data_i (bus_io.commit_data),
    .commit_tag_i  (bus_io.commit_tag),
`endif
    .tag_o         (bus_io.rs1_tag),
    .data_o        (bus_io.rs1_data)
  );

  regfile_read_port u_rd2 (
    .addr_i        (bus_io.rs2_addr),
    .data_arr_i    (data_q),
    .tag_arr_i     (tag_q),
`ifdef REGFILE_BYPASS_EN
    .commit_en_i   (bus_io.commit_en),
    .commit_reg_i  (bus_io.commit_reg),
    .commit_data_i (bus_io.commit_data),
    .commit_tag_i  (bus_io.commit_tag),
`endif
    .tag_o         (bus_io.rs2_tag),
    .data_o        (bus_io.rs2_data)
  );

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios plus a randomized phase
// against a behavioural model, with read expectations queued and compared in order.
module tb_regfile_rename;
  import regfile_rename_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_rename_if rf_if ();

  regfile_rename dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (rf_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string    name;
    bit       port;
    reg_idx_t addr;
    tag_t     tag;
    data_t    data;
  } rd_exp_t;

  rd_exp_t sb_q[$];

  tag_t        m_tag  [NUM_REGS];
  data_t       m_data [NUM_REGS];
  logic [31:0] m_cnt;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_rd(input string name, input bit port, input reg_idx_t a,
                           input tag_t t, input data_t d);
    rd_exp_t e;
    e.name = name;
    e.port = port;
    e.addr = a;
    e.tag  = t;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Pops each queued read, presents its address and compares the port output
  task automatic drain();
    rd_exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.port) rf_if.rs2_addr = e.addr;
      else        rf_if.rs1_addr = e.addr;
      #1;
      if (e.port) begin
        check_eq({e.name, ".tag"},  32'(rf_if.rs2_tag),  32'(e.tag));
        check_eq({e.name, ".data"}, rf_if.rs2_data, e.data);
      end else begin
        check_eq({e.name, ".tag"},  32'(rf_if.rs1_tag),  32'(e.tag));
        check_eq({e.name, ".data"}, rf_if.rs1_data, e.data);
      end
    end
  endtask

  task automatic clear();
    rf_if.commit_en   = 1'b0;
    rf_if.commit_reg  = '0;
    rf_if.commit_data = '0;
    rf_if.commit_tag  = '0;
    rf_if.rename_en   = 1'b0;
    rf_if.rename_reg  = '0;
    rf_if.rename_tag  = '0;
    rf_if.flush       = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rename(input reg_idx_t r, input tag_t t);
    rf_if.rename_en  = 1'b1;
    rf_if.rename_reg = r;
    rf_if.rename_tag = t;
  endtask

  task automatic do_commit(input reg_idx_t r, input tag_t t, input data_t d);
    rf_if.commit_en   = 1'b1;
    rf_if.commit_reg  = r;
    rf_if.commit_tag  = t;
    rf_if.commit_data = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_tag[i]  = TAG_FREE;
      m_data[i] = '0;
    end
    m_cnt = '0;
  endtask

  // Applies the currently driven inputs to the model as one clock edge would
  task automatic model_edge();
    if (rf_if.commit_en) begin
      m_cnt = m_cnt + 32'd1;
      if (rf_if.commit_reg != 0) begin
        if (m_tag[rf_if.commit_reg] == rf_if.commit_tag) m_tag[rf_if.commit_reg] = TAG_FREE;
        m_data[rf_if.commit_reg] = rf_if.commit_data;
      end
    end
    if (rf_if.flush) begin
      for (int i = 0; i < NUM_REGS; i++) m_tag[i] = TAG_FREE;
    end else if (rf_if.rename_en && rf_if.rename_reg != 0) begin
      m_tag[rf_if.rename_reg] = rf_if.rename_tag;
    end
  endtask

  initial begin
    reg_idx_t ra, rb;
    rst = 1'b0;
    clear();
    rf_if.rs1_addr = '0;
    rf_if.rs2_addr = '0;
    #12;
    expect_rd("reset_r5", 1'b0, 5'd5, TAG_FREE, 32'd0);
    drain();
    check_eq("reset_cnt", rf_if.retired_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Rename then matching commit frees the tag
    do_rename(5'd3, 4'd2);
    step(); clear();
    do_commit(5'd3, 4'd2, 32'hDEAD_BEEF);
    step(); clear();
    expect_rd("commit_r3", 1'b0, 5'd3, TAG_FREE, 32'hDEAD_BEEF);
    drain();
    check_eq("cnt_1", rf_if.retired_cnt, 32'd1);

    // Older commit behind a newer rename keeps the newer tag
    do_rename(5'd3, 4'd2);
    step();
    do_rename(5'd3, 4'd5);
    step(); clear();
    do_commit(5'd3, 4'd2, 32'd7);
    step(); clear();
    expect_rd("stale_commit_r3", 1'b1, 5'd3, 4'd5, 32'd7);
    drain();
    check_eq("cnt_2", rf_if.retired_cnt, 32'd2);

    // Same-cycle commit and rename: rename wins the tag
    do_rename(5'd4, 4'd1);
    step(); clear();
    do_commit(5'd4, 4'd1, 32'd9);
    do_rename(5'd4, 4'd6);
    step(); clear();
    expect_rd("commit_rename_r4", 1'b0, 5'd4, 4'd6, 32'd9);
    drain();
    check_eq("cnt_3", rf_if.retired_cnt, 32'd3);

    // Flush clears all tags, drops same-cycle rename, keeps same-cycle commit data
    do_rename(5'd7, 4'd3);
    step();
    do_rename(5'd8, 4'd4);
    step(); clear();
    expect_rd("pre_flush_r7", 1'b0, 5'd7, 4'd3, 32'd0);
    expect_rd("pre_flush_r8", 1'b1, 5'd8, 4'd4, 32'd0);
    drain();
    rf_if.flush = 1'b1;
    do_rename(5'd9, 4'd5);
    do_commit(5'd12, 4'd9, 32'h12);
    step(); clear();
    expect_rd("flush_r7", 1'b0, 5'd7, TAG_FREE, 32'd0);
    expect_rd("flush_r8", 1'b1, 5'd8, TAG_FREE, 32'd0);
    expect_rd("flush_r9", 1'b0, 5'd9, TAG_FREE, 32'd0);
    expect_rd("flush_r12", 1'b1, 5'd12, TAG_FREE, 32'h12);
    drain();
    check_eq("cnt_4", rf_if.retired_cnt, 32'd4);

    // Commit visible on a read port in the same cycle only with forwarding
    do_rename(5'd2, 4'd0);
    step(); clear();
    do_commit(5'd2, 4'd0, 32'd11);
`ifdef REGFILE_BYPASS_EN
    expect_rd("bypass_r2", 1'b1, 5'd2, TAG_FREE, 32'd11);
`else
    expect_rd("nobypass_r2", 1'b1, 5'd2, 4'd0, 32'd0);
`endif
    drain();
    step(); clear();
    expect_rd("after_commit_r2", 1'b1, 5'd2, TAG_FREE, 32'd11);
    drain();
    check_eq("cnt_5", rf_if.retired_cnt, 32'd5);

    // Register 0 ignores commit and rename, but the commit still counts
    do_rename(5'd0, 4'd3);
    do_commit(5'd0, 4'd3, 32'd5);
    step(); clear();
    expect_rd("r0_rd1", 1'b0, 5'd0, TAG_FREE, 32'd0);
    expect_rd("r0_rd2", 1'b1, 5'd0, TAG_FREE, 32'd0);
    drain();
    check_eq("cnt_6", rf_if.retired_cnt, 32'd6);

    // Asynchronous reset mid-cycle discards state and the pending commit
    do_rename(5'd10, 4'd7);
    step(); clear();
    do_commit(5'd10, 4'd7, 32'd55);
    #2;
    rst = 1'b0;
    expect_rd("async_rst_r10", 1'b0, 5'd10, TAG_FREE, 32'd0);
    expect_rd("async_rst_r3", 1'b1, 5'd3, TAG_FREE, 32'd0);
    drain();
    check_eq("async_rst_cnt", rf_if.retired_cnt, 32'd0);
    step(); clear();
    @(negedge clk);
    rst = 1'b1;
    expect_rd("post_rst_r10", 1'b0, 5'd10, TAG_FREE, 32'd0);
    drain();

    // Randomized traffic checked against the model
    model_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        rf_if.commit_en   = 1'b1;
        rf_if.commit_reg  = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
        rf_if.commit_data = $urandom;
        rf_if.commit_tag  = ($urandom_range(0, 3) != 0) ? m_tag[rf_if.commit_reg]
                                                         : tag_t'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1) begin
        do_rename(reg_idx_t'($urandom_range(0, NUM_REGS - 1)), tag_t'($urandom_range(0, 7)));
      end
      rf_if.flush = ($urandom_range(0, 15) == 0);
      model_edge();
      step(); clear();
      ra = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
      rb = reg_idx_t'($urandom_range(0, NUM_REGS - 1));
      expect_rd("rand_rd1", 1'b0, ra, m_tag[ra], m_data[ra]);
      expect_rd("rand_rd2", 1'b1, rb, m_tag[rb], m_data[rb]);
      drain();
      check_eq("rand_cnt", rf_if.retired_cnt, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
